// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the LEGv8 immediate extractor.
// Opcode fields are left-aligned slices of the instruction word; widths follow each format's match field.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_D    = 3'd1,
        FMT_CB   = 3'd2,
        FMT_B    = 3'd3,
        FMT_I    = 3'd4,
        FMT_IW   = 3'd5
    } imm_fmt_t;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;
    localparam logic [5:0]  OP_B    = 6'b000101;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    localparam logic [8:0]  OP_MOVZ = 9'b110100101;

    // Everything in a pipeline entry except the DATA_W-wide immediate.
    typedef struct packed {
        imm_fmt_t    fmt;
        logic        illegal;
        logic [31:0] instr;
    } imm_meta_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: picks the format from the opcode and
// produces the extended, optionally shifted immediate in DATA_W bits.
module imm_decode
    import imm_pkg::*;
#(
    parameter int DATA_W       = 64,
    parameter int SHIFT_BRANCH = 1
) (
    input  logic [31:0]       instr,
    output logic [DATA_W-1:0] imm,
    output imm_fmt_t          fmt,
    output logic              illegal
);

    logic [DATA_W-1:0] d_imm;
    logic [DATA_W-1:0] cb_imm;
    logic [DATA_W-1:0] b_imm;
    logic [DATA_W-1:0] i_imm;
    logic [DATA_W-1:0] iw_base;
    logic [5:0]        iw_shamt;

    assign d_imm    = {{(DATA_W-9){instr[20]}},  instr[20:12]};
    assign cb_imm   = {{(DATA_W-19){instr[23]}}, instr[23:5]};
    assign b_imm    = {{(DATA_W-26){instr[25]}}, instr[25:0]};
    assign i_imm    = {{(DATA_W-12){1'b0}},      instr[21:10]};
    assign iw_base  = {{(DATA_W-16){1'b0}},      instr[20:5]};
    assign iw_shamt = {instr[22:21], 4'b0000};

    // NOTE: every output gets a default first so no path through the if-chain infers a latch.
    always_comb begin
        imm     = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        if (instr[31:21] == OP_LDUR || instr[31:21] == OP_STUR) begin
            fmt = FMT_D;
            imm = d_imm;
        end else if (instr[31:24] == OP_CBZ || instr[31:24] == OP_CBNZ) begin
            fmt = FMT_CB;
            imm = (SHIFT_BRANCH != 0) ? (cb_imm << 2) : cb_imm;
        end else if (instr[31:26] == OP_B) begin
            fmt = FMT_B;
            imm = (SHIFT_BRANCH != 0) ? (b_imm << 2) : b_imm;
        end else if (instr[31:22] == OP_ADDI || instr[31:22] == OP_SUBI) begin
            fmt = FMT_I;
            imm = i_imm;
        end else if (instr[31:23] == OP_MOVZ) begin
            fmt = FMT_IW;
            // A 32-bit datapath cannot hold a halfword placed at bit 32 or 48.
            if (DATA_W == 32 && instr[22]) begin
                illegal = 1'b1;
            end else begin
                imm = iw_base << iw_shamt;
            end
        end else begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extractor: decode feeds a registered output entry
// backed by one skid entry, giving full throughput with a registered in_ready.
module imm_ext_pipe
    import imm_pkg::*;
#(
    parameter int DATA_W       = 64,
    parameter int SHIFT_BRANCH = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm,
    output imm_fmt_t          out_fmt,
    output logic              out_illegal,
    output logic [31:0]       out_instr
);

    logic [DATA_W-1:0] dec_imm;
    imm_fmt_t          dec_fmt;
    logic              dec_illegal;
    imm_meta_t         dec_meta;

    logic [DATA_W-1:0] skid_imm;
    imm_meta_t         skid_meta;
    logic              skid_valid;
    imm_meta_t         out_meta;

    logic accept;
    logic drain;
    logic skid_valid_nxt;

    imm_decode #(
        .DATA_W       (DATA_W),
        .SHIFT_BRANCH (SHIFT_BRANCH)
    ) u_decode (
        .instr   (in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    assign dec_meta = '{fmt: dec_fmt, illegal: dec_illegal, instr: in_instr};

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    // in_ready is low whenever the skid is full, so accept never coincides with skid_valid.
    assign skid_valid_nxt = skid_valid ? !drain : (accept && out_valid && !out_ready);

    assign out_fmt     = out_meta.fmt;
    assign out_illegal = out_meta.illegal;
    assign out_instr   = out_meta.instr;

    // NOTE: the skid payload is reset too, so a discarded bundle can never leak out after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            in_ready   <= 1'b1;
            out_imm    <= '0;
            out_meta   <= '0;
            skid_valid <= 1'b0;
            skid_imm   <= '0;
            skid_meta  <= '0;
        end else begin
            in_ready <= !skid_valid_nxt;
            if (drain) begin
                if (skid_valid) begin
                    out_imm    <= skid_imm;
                    out_meta   <= skid_meta;
                    skid_valid <= 1'b0;
                end else if (accept) begin
                    out_imm  <= dec_imm;
                    out_meta <= dec_meta;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (accept) begin
                if (out_valid) begin
                    skid_imm   <= dec_imm;
                    skid_meta  <= dec_meta;
                    skid_valid <= 1'b1;
                end else begin
                    out_imm   <= dec_imm;
                    out_meta  <= dec_meta;
                    out_valid <= 1'b1;
                end
            end
        end
    end

endmodule
